// File: rtl/l2_writeback_buffer_if.sv
// Handshake and bus bundle for the L2 write-back buffer.
// Groups the L2 write port, the L2 miss-fill read port, the DMEM access port and the empty flag.
// The buffer uses the slave modport; the L2/DMEM side (or a bench) uses the master modport.
interface l2_writeback_buffer_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  // L2 eviction writes
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  // L2 miss-fill reads
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  // DMEM access
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // status
  logic              empty;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, mem_ack,
    output wr_ready, rd_valid, rd_data, mem_req, mem_we, mem_addr, mem_wdata, empty
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, mem_ack,
    input  wr_ready, rd_valid, rd_data, mem_req, mem_we, mem_addr, mem_wdata, empty
  );
endinterface

// File: rtl/l2_writeback_buffer.sv
// Write-back buffer between L2 and DMEM: queues evictions, drains them in the background,
// and serves miss-fill reads with forwarding from pending writes (read hits answer next cycle).
// Ports: clk, reset (async active-high), bus (slave modport: wr_*, rd_*, mem_*, empty).
module l2_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_writeback_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE_WAIT, READ_WAIT} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;

  logic                rd_valid_q, mem_req_q, mem_we_q;
  logic [DATA_W-1:0]   rd_data_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  logic                wr_ready, wr_fire, drain_done, read_pending;
  logic                merge_hit, rd_hit;
  logic [PTR_W-1:0]    merge_idx;
  logic [DATA_W-1:0]   rd_hit_data;

  assign wr_ready   = (count != CNT_W'(DEPTH));
  assign wr_fire    = bus.wr_valid && wr_ready;
  assign drain_done = (state == WRITE_WAIT) && bus.mem_ack;
  // In the rd_valid cycle the requester may still hold rd_req; do not serve it twice.
  assign read_pending = bus.rd_req && !rd_valid_q;

  // Merge target: a valid matching entry, except the head while it is being written to DMEM
  // (its data is already on mem_wdata, so a new write must get its own entry).
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == bus.wr_addr) &&
          !((state == WRITE_WAIT) && (PTR_W'(i) == head))) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  // Read lookup: walk from oldest to youngest so the youngest match wins,
  // then let a write accepted this same cycle override everything.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (vld_q[idx] && (addr_q[idx] == bus.rd_addr)) begin
        rd_hit      = 1'b1;
        rd_hit_data = data_q[idx];
      end
    end
    if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
      rd_hit      = 1'b1;
      rd_hit_data = bus.wr_data;
    end
  end

  // Entry storage needs no reset; validity is tracked in vld_q.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (merge_hit) begin
        data_q[merge_idx] <= bus.wr_data;
      end else begin
        addr_q[tail] <= bus.wr_addr;
        data_q[tail] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vld_q       <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (wr_fire && !merge_hit) begin
        vld_q[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (drain_done) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({wr_fire && !merge_hit, drain_done})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (read_pending) begin
            if (rd_hit) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= rd_hit_data;
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.rd_addr;
              state      <= READ_WAIT;
            end
          end else if (count != '0) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q[head];
            // A write merging into the head on this very edge must go out with the new data.
            mem_wdata_q <= (wr_fire && merge_hit && (merge_idx == head)) ? bus.wr_data
                                                                         : data_q[head];
            state <= WRITE_WAIT;
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        READ_WAIT: begin
          if (bus.mem_ack) begin
            rd_data_q  <= bus.mem_rdata;
            rd_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.empty     = (count == '0) && (state == IDLE);
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed self-checking bench for l2_writeback_buffer.
// Drives inputs and samples outputs 1 ns after each rising edge.
// Each scenario task carries its own hand-computed expectations.
module tb_l2_writeback_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  l2_writeback_buffer_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  l2_writeback_buffer #(.DEPTH(4), .ADDR_W(30), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a DMEM write, checks it, then acks it for one cycle.
  task automatic drain_one(input logic [29:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout: no mem_req for addr %h within 20 cycles", a);
    end else begin
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== a || bus.mem_wdata !== d) begin
        errors++;
        $display("FAIL drain_beat: got we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata, a, d);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL drain_release: mem_req=%b after ack, want 0", bus.mem_req);
      end
    end
  endtask

  task automatic test_reset();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 0; bus.rd_addr = '0; bus.mem_rdata = '0; bus.mem_ack = 0;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.wr_ready, bus.rd_valid, bus.mem_req, bus.mem_we, bus.empty} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_flags: got wr_ready,rd_valid,mem_req,mem_we,empty=%b, want 10001",
               {bus.wr_ready, bus.rd_valid, bus.mem_req, bus.mem_we, bus.empty});
    end
    checks++;
    if (bus.rd_data !== 32'h0 || bus.mem_addr !== 30'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got rd_data=%h mem_addr=%h mem_wdata=%h, want all 0",
               bus.rd_data, bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_drain();
    bus.wr_valid = 1; bus.wr_addr = 30'h100; bus.wr_data = 32'hDEADBEEF;
    tick();
    bus.wr_valid = 0;
    checks++;
    if (bus.empty !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: empty=%b mem_req=%b, want 0 0", bus.empty, bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 30'h100 ||
        bus.mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_issue: req=%b we=%b addr=%h data=%h, want 1 1 100 deadbeef",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick(); tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h100 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: req=%b addr=%h empty=%b, want 1 100 0",
               bus.mem_req, bus.mem_addr, bus.empty);
    end
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL single_done: req=%b empty=%b, want 0 1", bus.mem_req, bus.empty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1; bus.wr_addr = 30'h10 + 30'(i); bus.wr_data = 32'hA0 + 32'(i);
      tick();
    end
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: wr_ready=%b after 4 writes, want 0", bus.wr_ready);
    end
    bus.wr_addr = 30'h14; bus.wr_data = 32'hA4;
    tick();
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.mem_addr !== 30'h10 || bus.mem_wdata !== 32'hA0) begin
      errors++;
      $display("FAIL fill_stall: wr_ready=%b addr=%h data=%h, want 0 10 a0",
               bus.wr_ready, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fill_free: wr_ready=%b mem_req=%b, want 1 0", bus.wr_ready, bus.mem_req);
    end
    tick();
    bus.wr_valid = 0;
    drain_one(30'h11, 32'hA1);
    drain_one(30'h12, 32'hA2);
    drain_one(30'h13, 32'hA3);
    drain_one(30'h14, 32'hA4);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_empty: empty=%b, want 1", bus.empty);
    end
  endtask

  task automatic test_merge_forward();
    bus.wr_valid = 1; bus.wr_addr = 30'h50; bus.wr_data = 32'h11111111;
    tick();
    bus.wr_addr = 30'h20; bus.wr_data = 32'hAAAA;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h50 || bus.mem_wdata !== 32'h11111111) begin
      errors++;
      $display("FAIL merge_issue: req=%b addr=%h data=%h, want 1 50 11111111",
               bus.mem_req, bus.mem_addr, bus.mem_wdata);
    end
    bus.wr_addr = 30'h20; bus.wr_data = 32'hBBBB;      // merges into the 0x20 entry
    tick();
    bus.wr_addr = 30'h50; bus.wr_data = 32'h22222222;  // head in flight: new entry
    tick();
    checks++;
    if (bus.mem_wdata !== 32'h11111111) begin
      errors++;
      $display("FAIL merge_head_excl: mem_wdata=%h, want 11111111", bus.mem_wdata);
    end
    bus.wr_valid = 0;
    bus.rd_req = 1; bus.rd_addr = 30'h20;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_rd_wait: rd_valid=%b during drain, want 0", bus.rd_valid);
    end
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hBBBB || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL merge_rd_hit: rd_valid=%b rd_data=%h mem_req=%b, want 1 0000bbbb 0",
               bus.rd_valid, bus.rd_data, bus.mem_req);
    end
    bus.rd_req = 0;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_rd_pulse: rd_valid=%b second cycle, want 0", bus.rd_valid);
    end
    drain_one(30'h20, 32'hBBBB);
    drain_one(30'h50, 32'h22222222);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL merge_empty: empty=%b, want 1", bus.empty);
    end
  endtask

  task automatic test_read_miss();
    bus.rd_req = 1; bus.rd_addr = 30'h30;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 30'h30) begin
      errors++;
      $display("FAIL miss_issue: req=%b we=%b addr=%h, want 1 0 30",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.wr_valid = 1; bus.wr_addr = 30'h30; bus.wr_data = 32'h9999;
    tick();
    bus.wr_valid = 0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL miss_wait: rd_valid=%b req=%b we=%b, want 0 1 0",
               bus.rd_valid, bus.mem_req, bus.mem_we);
    end
    bus.mem_rdata = 32'h1234; bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0; bus.mem_rdata = '0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1234 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_return: rd_valid=%b rd_data=%h req=%b, want 1 00001234 0",
               bus.rd_valid, bus.rd_data, bus.mem_req);
    end
    bus.rd_req = 0;
    drain_one(30'h30, 32'h9999);
  endtask

  task automatic test_same_cycle();
    bus.wr_valid = 1; bus.wr_addr = 30'h40; bus.wr_data = 32'h5555;
    bus.rd_req = 1; bus.rd_addr = 30'h40;
    tick();
    bus.wr_valid = 0; bus.rd_req = 0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h5555 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL same_fwd: rd_valid=%b rd_data=%h req=%b, want 1 00005555 0",
               bus.rd_valid, bus.rd_data, bus.mem_req);
    end
    drain_one(30'h40, 32'h5555);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL same_empty: empty=%b, want 1", bus.empty);
    end
  endtask

  task automatic test_reset_midaccess();
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1; bus.wr_addr = 30'h60 + 30'(i); bus.wr_data = 32'hC0 + 32'(i);
      tick();
    end
    bus.wr_valid = 0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: req=%b we=%b, want 1 1", bus.mem_req, bus.mem_we);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: req=%b empty=%b wr_ready=%b, want 0 1 1",
               bus.mem_req, bus.empty, bus.wr_ready);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_quiet: cycle %0d req=%b empty=%b, want 0 1",
                 i, bus.mem_req, bus.empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_fill();
    test_merge_forward();
    test_read_miss();
    test_same_cycle();
    test_reset_midaccess();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_writeback_buffer.md
Name: l2_writeback_buffer

Overview:
Write-back buffer between the L2 cache subsystem and data memory (DMEM).
- Accepts L2 victim/eviction writes into a small FIFO and drains them to DMEM in the background.
- Serves L2 miss-fill reads, forwarding from pending writes so the L2 never reads stale DMEM data.
- Decouples L2 eviction timing from DMEM latency.

Parameters:
DEPTH, 4, number of buffered write entries; power of 2, at least 2
ADDR_W, 30, word-address width (byte address bits 31:2)
DATA_W, 32, data word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  L2 eviction write request
wr_ready  out  1  buffer can accept a write
wr_addr  in  ADDR_W  eviction word address
wr_data  in  DATA_W  eviction data
rd_req  in  1  L2 miss-fill read request; held until rd_valid
rd_addr  in  ADDR_W  fill word address; stable while rd_req is high
rd_valid  out  1  one-cycle pulse: rd_data valid
rd_data  out  DATA_W  fill data
mem_req  out  1  DMEM access request; held until mem_ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  DMEM word address
mem_wdata  out  DATA_W  DMEM write data
mem_rdata  in  DATA_W  DMEM read data; valid when mem_ack is high on a read
mem_ack  in  1  DMEM completes the current access this cycle
empty  out  1  no pending writes and FSM is in IDLE

Behaviour:
- Reset is asynchronous and active-high. It clears all entry valid bits, head, tail and count, and puts the FSM in IDLE.
- Reset values: wr_ready=1, rd_valid=0, rd_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, empty=1.
- Reset mid-access drops mem_req immediately. Pending writes are discarded.
- Storage is a circular FIFO with head, tail and count; pointers wrap modulo DEPTH.
- wr_ready = (count != DEPTH), computed from registered count only. A drain completing in the same cycle does not free a slot early.

Write accept (wr_valid && wr_ready at the rising edge):
- Merge: if a valid entry matches wr_addr, overwrite its data; count is unchanged.
- The head entry is excluded from merging while the FSM is in WRITE_WAIT. In that case a new entry is allocated.
- Otherwise: write the entry at tail, then tail++ and count++.

FSM states: IDLE, WRITE_WAIT, READ_WAIT.
- IDLE, rd_req=1, read hits: the read hits if the incoming accepted write's address equals rd_addr, or any valid entry matches rd_addr.
  - Priority for the returned data: incoming write data, then the youngest matching entry.
  - Next cycle: rd_valid=1 with that data. Stay in IDLE. DMEM is not accessed.
- IDLE, rd_req=1, read misses: drive mem_req=1, mem_we=0, mem_addr=rd_addr (registered). Go to READ_WAIT. Reads take priority over draining.
- IDLE, rd_req=0, count>0: drive mem_req=1, mem_we=1, with mem_addr and mem_wdata taken from the head entry. Go to WRITE_WAIT.
- READ_WAIT, on mem_ack: latch mem_rdata into rd_data and drop mem_req. rd_valid=1 in the following cycle. Return to IDLE.
- READ_WAIT, before mem_ack: an incoming write to rd_addr does not alter the in-flight read.
- WRITE_WAIT, on mem_ack: invalidate the head entry, head++, count--, drop mem_req, return to IDLE.
- An rd_req arriving during WRITE_WAIT waits. It is evaluated in IDLE after the write completes, so it sees the post-drain buffer.
- A simultaneous write accept and drain completion updates count by the net effect (count unchanged).
- rd_valid is high for exactly one cycle per request. rd_req must be held until then and deasserted in the rd_valid cycle, or on the following edge at the latest. The block does not re-serve in that cycle.
- mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
- empty = (count==0) && (state==IDLE).

Test Plan:
- Reset, then wr 0x100/0xDEADBEEF with mem_ack delayed 3 cycles -> mem_req=1, we=1, addr 0x100; 3 cycles later count=0 and empty=1.
- Fill 4 writes 0x10..0x13 with mem_ack held low -> wr_ready=0 after the 4th; a 5th wr_valid is stalled. One mem_ack -> wr_ready=1 the next cycle, and the 0x10 write reaches DMEM first.
- Buffer holds 0x20/0xAAAA, then wr 0x20/0xBBBB -> merged, count=1. rd_req 0x20 -> rd_valid next cycle, rd_data=0xBBBB, no DMEM read issued.
- rd_req 0x30 (not buffered) with mem_rdata=0x1234 acked after 2 cycles -> mem_we=0, addr 0x30; rd_valid=1 with 0x1234 one cycle after ack.
- wr 0x40/0x5555 and rd_req 0x40 in the same cycle, buffer empty -> rd_data=0x5555 next cycle, entry still queued for drain.
- Assert reset while in WRITE_WAIT with 3 entries -> mem_req=0 immediately, count=0, empty=1; no further mem_req without new writes.
